serial_frame_tx: RTL and testbench

Serial frame transmitter for the single-wire serial input `x` used by the flip-flop state machines in this codebase. On a start request it latches a WIDTH-bit parallel word and sends one frame on `x`: a start bit, the data LSB first, then an even-parity bit. It is the transmit end that drives sequence-detecting machines under test. The block exposes its current state on `S` in the same way those machines do.

---
 rtl/serial_frame_tx.sv | 105 ++++++++++
 tb/tb_serial_frame_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB first, even parity.
// All outputs are registered; next values are computed combinationally from state.
module serial_frame_tx #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             x,
    output logic             busy,
    output logic             done,
    output logic [1:0]       S
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_START  = 2'b01,
        ST_DATA   = 2'b10,
        ST_PARITY = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_par;
    logic             w_par_nxt;
    logic             r_x;
    logic             w_x_nxt;
    logic             r_done;
    logic             w_done_nxt;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_x     <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_par   <= w_par_nxt;
            r_x     <= w_x_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // x is loaded with the value belonging to the state being entered,
    // so the line changes on the same edge as S.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_par_nxt   = r_par;
        w_x_nxt     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_START;
                    w_shift_nxt = data;
                    w_par_nxt   = ^data;
                    w_cnt_nxt   = '0;
                    w_x_nxt     = 1'b1;
                end
            end
            ST_START: begin
                w_state_nxt = ST_DATA;
                w_x_nxt     = r_shift[0];
                w_shift_nxt = r_shift >> 1;
            end
            ST_DATA: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_state_nxt = ST_PARITY;
                    w_x_nxt     = r_par;
                end else begin
                    w_x_nxt     = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                end
            end
            ST_PARITY: begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign x    = r_x;
    assign done = r_done;
    assign S    = r_state;
    assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: an 8-bit instance for the main frames
// and a 2-bit instance for the counter-wrap corner.
module tb_serial_frame_tx;

    logic       CLK;
    logic       RESET;
    logic       start;
    logic [7:0] data;
    logic       x;
    logic       busy;
    logic       done;
    logic [1:0] S;
    logic       start2;
    logic [1:0] data2;
    logic       x2;
    logic       busy2;
    logic       done2;
    logic [1:0] S2;

    int n_checks = 0;
    int n_errors = 0;

    serial_frame_tx #(.WIDTH(8)) u_dut8 (
        .CLK   (CLK),
        .RESET (RESET),
        .start (start),
        .data  (data),
        .x     (x),
        .busy  (busy),
        .done  (done),
        .S     (S)
    );

    serial_frame_tx #(.WIDTH(2)) u_dut2 (
        .CLK   (CLK),
        .RESET (RESET),
        .start (start2),
        .data  (data2),
        .x     (x2),
        .busy  (busy2),
        .done  (done2),
        .S     (S2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_quiet8(input string tag);
        chk({tag, "_S"}, S, 2'b00);
        chk({tag, "_x"}, x, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
    endtask

    // seq[i] is the i-th transmitted data bit, written out by hand.
    task automatic run_frame(input logic [7:0] d, input logic [7:0] seq, input logic par,
                             input bit keep, input int disturb);
        start = 1'b1;
        data  = d;
        tick();
        if (!keep) start = 1'b0;
        chk("start_S", S, 2'b01);
        chk("start_x", x, 1'b1);
        chk("start_busy", busy, 1'b1);
        chk("start_done", done, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("data_S", S, 2'b10);
            chk("data_x", x, seq[i]);
            chk("data_busy", busy, 1'b1);
            if (disturb >= 0 && i == disturb) begin
                data  = 8'hFF;
                start = 1'b1;
            end else if (disturb >= 0 && i == disturb + 1) begin
                start = 1'b0;
            end
        end
        tick();
        chk("par_S", S, 2'b11);
        chk("par_x", x, par);
        chk("par_busy", busy, 1'b1);
        tick();
        chk("done_S", S, 2'b00);
        chk("done_x", x, 1'b0);
        chk("done_busy", busy, 1'b0);
        chk("done_pulse", done, 1'b1);
        if (!keep) begin
            tick();
            chk_quiet8("after");
        end
    endtask

    initial begin
        RESET  = 1'b0;
        start  = 1'b0;
        data   = '0;
        start2 = 1'b0;
        data2  = '0;

        // Reset held with random inputs, sampled at odd points in the clock.
        for (int i = 0; i < 6; i++) begin
            start  = 1'($urandom);
            data   = 8'($urandom);
            start2 = 1'($urandom);
            data2  = 2'($urandom);
            #3;
            chk_quiet8("rst");
            chk("rst2_S", S2, 2'b00);
            chk("rst2_x", x2, 1'b0);
            chk("rst2_busy", busy2, 1'b0);
            chk("rst2_done", done2, 1'b0);
        end
        @(negedge CLK);
        start  = 1'b0;
        start2 = 1'b0;
        RESET  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet8("post_rst");
        end

        // A5: 1,0,1,0,0,1,0,1 parity 0
        run_frame(8'hA5, 8'b1010_0101, 1'b0, 1'b0, -1);
        // 07: 1,1,1,0,0,0,0,0 parity 1; data/start disturbed at 3rd data bit
        run_frame(8'h07, 8'b0000_0111, 1'b1, 1'b0, 2);
        tick();
        chk_quiet8("no_second");

        // 3C with start held: 0,0,1,1,1,1,0,0 parity 0, back to back
        run_frame(8'h3C, 8'b0011_1100, 1'b0, 1'b1, -1);
        run_frame(8'h3C, 8'b0011_1100, 1'b0, 1'b1, -1);
        run_frame(8'h3C, 8'b0011_1100, 1'b0, 1'b1, -1);
        start = 1'b0;
        tick();
        chk_quiet8("b2b_end");

        // Reset during 4th data bit of A5
        start = 1'b1;
        data  = 8'hA5;
        tick();
        start = 1'b0;
        chk("mr_start_S", S, 2'b01);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mr_data_S", S, 2'b10);
        end
        chk("mr_bit3_x", x, 1'b0);
        #2;
        RESET = 1'b0;
        #1;
        chk_quiet8("mr_async");
        tick();
        chk_quiet8("mr_held");
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet8("mr_after");
        end
        // 01: 1,0,0,0,0,0,0,0 parity 1
        run_frame(8'h01, 8'b0000_0001, 1'b1, 1'b0, -1);

        // WIDTH=2, data 2'b10: 1, 0, 1, parity 1
        start2 = 1'b1;
        data2  = 2'b10;
        tick();
        start2 = 1'b0;
        chk("w2_start_S", S2, 2'b01);
        chk("w2_start_x", x2, 1'b1);
        chk("w2_start_busy", busy2, 1'b1);
        tick();
        chk("w2_d0_S", S2, 2'b10);
        chk("w2_d0_x", x2, 1'b0);
        tick();
        chk("w2_d1_S", S2, 2'b10);
        chk("w2_d1_x", x2, 1'b1);
        tick();
        chk("w2_par_S", S2, 2'b11);
        chk("w2_par_x", x2, 1'b1);
        chk("w2_par_busy", busy2, 1'b1);
        tick();
        chk("w2_done_S", S2, 2'b00);
        chk("w2_done_busy", busy2, 1'b0);
        chk("w2_done_pulse", done2, 1'b1);
        chk("w2_done_x", x2, 1'b0);
        tick();
        chk("w2_after_done", done2, 1'b0);
        chk("w2_after_S", S2, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
